// File: rtl/hist_eq_pkg.sv
// Shared types for the histogram-equalisation datapath: sequencer states and CDF width helper.
// No logic, no latency, no flow control.
package hist_eq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INPUT,
    ST_CDF,
    ST_CALC,
    ST_OUTPUT,
    ST_DONE,
    ST_ERR
  } hist_eq_state_t;

  // CDF values must hold PIXEL_COUNT itself, hence the extra bit.
  function automatic int cdfWidth(input int pixelCount);
    return $clog2(pixelCount) + 1;
  endfunction

  localparam int DEFAULT_PIXEL_COUNT = 65536;
  localparam int DEFAULT_CDF_W       = cdfWidth(DEFAULT_PIXEL_COUNT);

endpackage

// File: rtl/hist_eq_watchdog.sv
// Per-stage cycle counter; expired is combinational in the cycle the count would reach all-ones.
// No flow control: clear marks the first cycle of a stage, tick is high for every cycle in a stage.
module hist_eq_watchdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [TIMEOUT_W-1:0] count;
  logic [TIMEOUT_W-1:0] countEff;
  logic [TIMEOUT_W-1:0] countNext;

  // The first stage cycle counts from zero regardless of what the previous stage left behind.
  always_comb begin
    countEff  = clear ? '0 : count;
    countNext = countEff + TIMEOUT_W'(1);
  end

  assign expired = tick && (countNext == '1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= countNext;
    end
  end

endmodule

// File: rtl/hist_eq_sequencer.sv
// Frame sequencer: input -> CDF -> output stages via start/done pulses; output_start 2 cycles after cdf_done.
// No backpressure; done pulses outside their state are dropped. Option: HIST_EQ_SEQ_WATCHDOG_EN (stage timeout).
module hist_eq_sequencer
  import hist_eq_pkg::*;
#(
  parameter int PIXEL_COUNT = DEFAULT_PIXEL_COUNT,
  parameter int CDF_W       = DEFAULT_CDF_W,
  parameter int FRAME_CNT_W = 8,
  parameter int TIMEOUT_W   = 20
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   input_start,
  input  logic                   input_done,
  output logic                   cdf_start,
  input  logic                   cdf_done,
  input  logic [CDF_W-1:0]       cdf_min,
  output logic                   output_start,
  input  logic                   output_done,
  output logic [CDF_W-1:0]       cdf_min_out,
  output logic [CDF_W-1:0]       divisor,
  output logic                   flat,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [CDF_W-1:0] PIX_CNT = CDF_W'(PIXEL_COUNT);

  hist_eq_state_t state;

  logic inputDoneQ, cdfDoneQ, outputDoneQ;
  logic inputDoneEv, cdfDoneEv, outputDoneEv;
  logic stageTimeout;

  // Only a fresh assertion counts, so a done held high is one event and cannot leak into the next stage.
  assign inputDoneEv  = input_done  && !inputDoneQ;
  assign cdfDoneEv    = cdf_done    && !cdfDoneQ;
  assign outputDoneEv = output_done && !outputDoneQ;

`ifdef HIST_EQ_SEQ_WATCHDOG_EN
  logic inStage;
  assign inStage = (state == ST_INPUT) || (state == ST_CDF) || (state == ST_OUTPUT);

  hist_eq_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) uWatchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (input_start | cdf_start | output_start),
    .tick    (inStage),
    .expired (stageTimeout)
  );
`else
  // Without the watchdog each stage waits indefinitely; ERR is unreachable.
  assign stageTimeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      input_start  <= 1'b0;
      cdf_start    <= 1'b0;
      output_start <= 1'b0;
      cdf_min_out  <= '0;
      divisor      <= '0;
      flat         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      frame_count  <= '0;
      inputDoneQ   <= 1'b0;
      cdfDoneQ     <= 1'b0;
      outputDoneQ  <= 1'b0;
    end else begin
      input_start  <= 1'b0;
      cdf_start    <= 1'b0;
      output_start <= 1'b0;
      done         <= 1'b0;
      inputDoneQ   <= input_done;
      cdfDoneQ     <= cdf_done;
      outputDoneQ  <= output_done;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_INPUT;
            input_start <= 1'b1;
            busy        <= 1'b1;
            error       <= 1'b0;
          end
        end
        ST_INPUT: begin
          if (inputDoneEv) begin
            state     <= ST_CDF;
            cdf_start <= 1'b1;
          end else if (stageTimeout) begin
            state <= ST_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_CDF: begin
          if (cdfDoneEv) begin
            state       <= ST_CALC;
            cdf_min_out <= cdf_min;
          end else if (stageTimeout) begin
            state <= ST_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_CALC: begin
          // A degenerate frame would give a zero or wrapped divisor; force 1 so the divider stays sane.
          if (cdf_min_out >= PIX_CNT) begin
            divisor <= CDF_W'(1);
            flat    <= 1'b1;
          end else begin
            divisor <= PIX_CNT - cdf_min_out;
            flat    <= 1'b0;
          end
          state        <= ST_OUTPUT;
          output_start <= 1'b1;
        end
        ST_OUTPUT: begin
          if (outputDoneEv) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            frame_count <= frame_count + FRAME_CNT_W'(1);
          end else if (stageTimeout) begin
            state <= ST_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Directed bench for hist_eq_sequencer (PIXEL_COUNT=16, CDF_W=5, FRAME_CNT_W=2, TIMEOUT_W=4).
// Define HIST_EQ_SEQ_WATCHDOG_EN to include the stage-timeout vectors.
module tb_hist_eq_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, input_done, cdf_done, output_done;
  logic [4:0] cdf_min;
  logic       input_start, cdf_start, output_start;
  logic [4:0] cdf_min_out, divisor;
  logic       flat, busy, done, error;
  logic [1:0] frame_count;

  int checks   = 0;
  int failures = 0;
  int inStartSeen  = 0;
  int cdfStartSeen = 0;
  int outStartSeen = 0;

  hist_eq_sequencer #(
    .PIXEL_COUNT (16),
    .CDF_W       (5),
    .FRAME_CNT_W (2),
    .TIMEOUT_W   (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .input_start  (input_start),
    .input_done   (input_done),
    .cdf_start    (cdf_start),
    .cdf_done     (cdf_done),
    .cdf_min      (cdf_min),
    .output_start (output_start),
    .output_done  (output_done),
    .cdf_min_out  (cdf_min_out),
    .divisor      (divisor),
    .flat         (flat),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .frame_count  (frame_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (input_start)  inStartSeen++;
    if (cdf_start)    cdfStartSeen++;
    if (output_start) outStartSeen++;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkAllZero(input string pfx);
    checkEq({pfx, "_input_start"},  input_start,  0);
    checkEq({pfx, "_cdf_start"},    cdf_start,    0);
    checkEq({pfx, "_output_start"}, output_start, 0);
    checkEq({pfx, "_cdf_min_out"},  cdf_min_out,  0);
    checkEq({pfx, "_divisor"},      divisor,      0);
    checkEq({pfx, "_flat"},         flat,         0);
    checkEq({pfx, "_busy"},         busy,         0);
    checkEq({pfx, "_done"},         done,         0);
    checkEq({pfx, "_error"},        error,        0);
    checkEq({pfx, "_frame_count"},  frame_count,  0);
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // Drives IDLE -> OUTPUT; returns in the first OUTPUT cycle.
  task automatic frameHead(input logic [4:0] minVal, input int expDiv, input int expFlat);
    start = 1'b1;
    step();
    start = 1'b0;
    checkEq("input_start_rise", input_start, 1);
    checkEq("busy_on", busy, 1);
    checkEq("error_cleared_on_start", error, 0);
    step();
    checkEq("input_start_width", input_start, 0);
    step();
    input_done = 1'b1;
    step();
    input_done = 1'b0;
    checkEq("cdf_start_rise", cdf_start, 1);
    step();
    checkEq("cdf_start_width", cdf_start, 0);
    cdf_min  = minVal;
    cdf_done = 1'b1;
    step();
    cdf_done = 1'b0;
    cdf_min  = 5'd31;
    checkEq("calc_no_output_start", output_start, 0);
    step();
    checkEq("output_start_rise", output_start, 1);
    checkEq("divisor", divisor, expDiv);
    checkEq("flat", flat, expFlat);
    checkEq("cdf_min_out", cdf_min_out, minVal);
  endtask

  // From the first OUTPUT cycle to the IDLE after DONE.
  task automatic frameTail(input int expCount);
    step();
    checkEq("output_start_width", output_start, 0);
    output_done = 1'b1;
    step();
    output_done = 1'b0;
    checkEq("done_pulse", done, 1);
    checkEq("frame_count", frame_count, expCount);
    checkEq("busy_in_done", busy, 1);
    step();
    checkEq("done_width", done, 0);
    checkEq("busy_off", busy, 0);
  endtask

  initial begin
    int wrapSeq[5];
    wrapSeq = '{1, 2, 3, 0, 1};

    reset_n     = 1'b0;
    start       = 1'b0;
    input_done  = 1'b0;
    cdf_done    = 1'b0;
    output_done = 1'b0;
    cdf_min     = 5'd0;
    step();
    step();
    checkAllZero("reset");
    reset_n = 1'b1;
    step();

    // Nominal frame and divisor boundaries: 16-4, flat at 16, last non-flat at 15, full range at 0.
    frameHead(5'd4, 12, 0);
    frameTail(1);
    frameHead(5'd16, 1, 1);
    frameTail(2);
    frameHead(5'd15, 1, 0);
    frameTail(3);
    frameHead(5'd0, 16, 0);
    frameTail(0);

    // Spurious done/start events must not move the FSM.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cdf_done = 1'b1;
    step();
    cdf_done    = 1'b0;
    output_done = 1'b1;
    step();
    output_done = 1'b0;
    step();
    checkEq("spur_busy_input", busy, 1);
    checkEq("spur_no_cdf_start", cdf_start, 0);
    checkEq("spur_no_output_start", output_start, 0);
    checkEq("spur_no_done", done, 0);
    checkEq("spur_frame_count_held", frame_count, 0);
    input_done = 1'b1;
    step();
    input_done = 1'b0;
    checkEq("spur_cdf_start", cdf_start, 1);
    step();
    start      = 1'b1;
    input_done = 1'b1;
    step();
    start      = 1'b0;
    input_done = 1'b0;
    step();
    checkEq("spur_no_input_start", input_start, 0);
    checkEq("spur_no_cdf_restart", cdf_start, 0);
    checkEq("spur_in_cdf_no_ostart", output_start, 0);
    cdf_min  = 5'd8;
    cdf_done = 1'b1;
    step();
    cdf_done = 1'b0;
    step();
    checkEq("spur_output_start", output_start, 1);
    checkEq("spur_divisor", divisor, 8);
    frameTail(1);
    checkEq("input_start_pulses", inStartSeen, 5);
    checkEq("cdf_start_pulses", cdfStartSeen, 5);
    checkEq("output_start_pulses", outStartSeen, 5);

    // Reset asserted while in CDF clears everything immediately.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    input_done = 1'b1;
    step();
    input_done = 1'b0;
    checkEq("pre_reset_in_cdf", cdf_start, 1);
    reset_n = 1'b0;
    #2;
    checkAllZero("midreset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();
    frameHead(5'd4, 12, 0);
    frameTail(1);

    // Frame counter wraps at 2 bits.
    resetDut();
    step();
    for (int f = 0; f < 5; f++) begin
      frameHead(5'd2, 14, 0);
      frameTail(wrapSeq[f]);
    end

`ifdef HIST_EQ_SEQ_WATCHDOG_EN
    // Withheld output_done: 15 cycles in OUTPUT, then ERR.
    frameHead(5'd4, 12, 0);
    repeat (14) step();
    checkEq("wd_busy_cycle15", busy, 1);
    checkEq("wd_no_error_cycle15", error, 0);
    step();
    checkEq("wd_error_set", error, 1);
    checkEq("wd_busy_drop", busy, 0);
    checkEq("wd_no_done", done, 0);
    step();
    checkEq("wd_error_sticky", error, 1);
    checkEq("wd_frame_count_held", frame_count, 1);
    // output_done on the 15th OUTPUT cycle beats the timeout.
    frameHead(5'd4, 12, 0);
    repeat (14) step();
    output_done = 1'b1;
    step();
    output_done = 1'b0;
    checkEq("wd_late_done", done, 1);
    checkEq("wd_late_no_error", error, 0);
    checkEq("wd_late_frame_count", frame_count, 2);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
